// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - memory-port stage: one req/ready transaction per command, holds IR and MDR
// Optional feature: define MEM_TIMEOUT_EN to enable the REQ wait watchdog (TIMEOUT cycles).
module mem_port_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] alu_out,
  input  logic [DW-1:0] wdata,
  input  logic          i_or_d,
  input  logic          ireg_enab,
  input  logic          mem_enab,
  input  logic          mdr_load,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] mdr,
  output logic          stall,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  typedef enum logic [1:0] {T_NONE, T_IR, T_MDR} tgt_t;

  state_t state, state_nxt;
  tgt_t   tgt_q, cmd_tgt;

  logic          any_cmd, multi_cmd, cmd_err, cmd_we, accept, capture, abort;
  logic [AW-1:0] sel_addr;

  assign any_cmd   = ireg_enab | mem_enab | mdr_load;
  assign multi_cmd = (ireg_enab & mem_enab) | (ireg_enab & mdr_load) | (mem_enab & mdr_load);
  assign sel_addr  = i_or_d ? alu_out : pc;
  assign cmd_err   = multi_cmd | (sel_addr[1:0] != 2'b00) | (~i_or_d & (mem_enab | mdr_load));
  // Priority ireg_enab > mem_enab > mdr_load decides the single command that runs
  assign cmd_we    = ~ireg_enab & mem_enab;
  assign cmd_tgt   = ireg_enab ? T_IR : (mem_enab ? T_NONE : T_MDR);
  assign accept    = (state == S_IDLE) & any_cmd;
  assign capture   = (state == S_REQ) & mem_ready;

  assign stall   = accept | (state == S_REQ);
  assign mem_req = (state == S_REQ);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;

  assign abort = (state == S_REQ) & ~mem_ready & (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wait_cnt <= '0;
    else if (accept)
      wait_cnt <= '0;
    else if ((state == S_REQ) && !mem_ready)
      wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_cmd) state_nxt = S_REQ;
      S_REQ:   if (mem_ready || abort) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      tgt_q     <= T_NONE;
      instr     <= '0;
      mdr       <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr  <= {sel_addr[AW-1:2], 2'b00};
        mem_we    <= cmd_we;
        mem_wdata <= wdata;
        tgt_q     <= cmd_tgt;
        if (cmd_err) bus_err <= 1'b1;
      end
      if (capture) begin
        if (tgt_q == T_IR)  instr <= mem_rdata;
        if (tgt_q == T_MDR) mdr   <= mem_rdata;
      end
      if (abort) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - randomized self-checking bench for mem_port_ctrl against a transaction-level model
module tb_mem_port_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc = '0, alu_out = '0, wdata = '0, mem_rdata = '0;
  logic        i_or_d = 1'b0, ireg_enab = 1'b0, mem_enab = 1'b0, mdr_load = 1'b0, mem_ready = 1'b0;
  logic [31:0] instr, mdr, mem_addr, mem_wdata;
  logic        stall, bus_err, mem_req, mem_we;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_instr = '0, exp_mdr = '0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  mem_port_ctrl #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .i_or_d(i_or_d), .ireg_enab(ireg_enab), .mem_enab(mem_enab), .mdr_load(mdr_load),
    .instr(instr), .mdr(mdr), .stall(stall), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // waits < 0 means the memory never answers
  task automatic run_cmd(input logic f, input logic s, input logic l, input logic iod,
                         input logic [31:0] pc_v, input logic [31:0] alu_v,
                         input logic [31:0] wd_v, input logic [31:0] rd_v, input int waits);
    logic [31:0] a;
    logic        err, is_store;
    int          k;
    @(negedge clk);
    ireg_enab = f; mem_enab = s; mdr_load = l; i_or_d = iod;
    pc = pc_v; alu_out = alu_v; wdata = wd_v;
    a        = iod ? alu_v : pc_v;
    is_store = !f && s;
    err      = (int'(f) + int'(s) + int'(l) > 1) || (a[1:0] != 2'b00) || (!iod && (s || l));
    k = 0;
    while (k < 300) begin
      mem_ready = (k == 0) ? 1'($urandom_range(0, 1)) : (waits >= 0 && k == waits + 1);
      mem_rdata = (k > 0 && mem_ready) ? rd_v : $urandom;
      #1;
      if (!stall) break;
      if (k >= 1) begin
        check("mem_req", {31'd0, mem_req}, 32'd1);
        check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("mem_we", {31'd0, mem_we}, {31'd0, is_store});
        if (is_store) check("mem_wdata", mem_wdata, wd_v);
      end
      @(negedge clk);
      k++;
    end
    if (waits >= 0) begin
      if (f) exp_instr = rd_v;
      else if (!s && l) exp_mdr = rd_v;
      check("stall_cycles", k, waits + 2);
    end else begin
      err = 1'b1;
      check("timeout_release", {31'd0, k < 300}, 32'd1);
    end
    exp_err = exp_err | err;
    check("instr", instr, exp_instr);
    check("mdr", mdr, exp_mdr);
    check("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
    ireg_enab = 1'b0; mem_enab = 1'b0; mdr_load = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic run_random(input bit legal);
    logic [2:0]  c;
    logic        iod;
    logic [31:0] a;
    if (legal) begin
      c   = 3'b001 << $urandom_range(0, 2);
      iod = c[0] ? 1'($urandom_range(0, 1)) : 1'b1;
      a   = $urandom & 32'hFFFF_FFFC;
    end else begin
      c   = 3'($urandom_range(1, 7));
      iod = 1'($urandom_range(0, 1));
      a   = $urandom;
    end
    run_cmd(c[0], c[1], c[2], iod, a, ($urandom & 32'hFFFF_FFFC) | (a & 32'd3),
            $urandom, $urandom, $urandom_range(0, 4));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_instr", instr, 32'd0);
    check("rst_mdr", mdr, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);

    run_cmd(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h2008_0005, 0);
    run_cmd(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'h0, 32'hDEAD_BEEF, 3);
    run_cmd(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h104, 32'h1234, $urandom, 2);
    for (int i = 0; i < 30; i++) run_random(1'b1);

    run_cmd(1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h300, 32'h55, 32'hCAFE_0001, 1);
    run_cmd(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h102, 32'h0, 32'h0000_0077, 0);

    @(negedge clk);
    ireg_enab = 1'b0; mem_enab = 1'b0; mdr_load = 1'b1; i_or_d = 1'b1; alu_out = 32'h200;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_req_before_rst", {31'd0, mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    exp_instr = '0; exp_mdr = '0; exp_err = 1'b0;
    check("rst_async_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_async_instr", instr, 32'd0);
    check("rst_async_mdr", mdr, 32'd0);
    check("rst_async_bus_err", {31'd0, bus_err}, 32'd0);
    mdr_load = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    check("post_rst_mem_req", {31'd0, mem_req}, 32'd0);

    for (int i = 0; i < 20; i++) run_random(1'b0);

`ifdef MEM_TIMEOUT_EN
    run_cmd(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'h0, 32'h1, -1);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
